voice_alloc: RTL and testbench
==============================

// Module: voice_alloc
// PURPOSE
//  Polyphonic voice allocator and configuration sequencer for the 64-oscillator wave generator.
//  Accepts note-on / note-off events over a valid/ready handshake and keeps a per-voice table
//  (active bit, 7-bit note). Writes the chosen oscillator's waveform and target frequency
//  through the generator's osc-select / valid-pulse configuration port.
//  Sits between the MIDI/event decoder and the wave generator. Runs in the 48MHz domain.
// PARAMETERS
//  NUM_VOICES  64  oscillator count; must be a power of 2; OSC_W = $clog2(NUM_VOICES)
//  FREQ_W      24  target frequency width in Hz; 0 = silence
// PORTS
//  i_clk48      in   1        48MHz clock
//  i_rst48_n    in   1        asynchronous active-low reset
//  i_note_valid in   1        event valid
//  o_note_ready out  1        event ready; transfer when valid && ready
//  i_note_on    in   1        1 = note-on, 0 = note-off
//  i_note       in   7        MIDI note number
//  i_freq       in   FREQ_W   target frequency for note-on (ignored for note-off)
//  i_wav        in   8        waveform select for note-on (0 saw, 1 square, 2 tri, 3 sine)
//  i_all_off    in   1        panic pulse: silence and free all voices
//  o_osc_sel    out  OSC_W    oscillator select to generator
//  o_t_freq     out  FREQ_W   target frequency to generator
//  o_tf_valid   out  1        frequency write pulse (o_osc_sel already stable >=1 cycle)
//  o_wav_sel    out  8        waveform select to generator
//  o_ws_valid   out  1        waveform write pulse (o_osc_sel already stable >=1 cycle)
//  o_drop       out  1        1-cycle pulse: note-on discarded, no voice available
//  o_active_cnt out  OSC_W+1  number of active voices
// BEHAVIOUR
//  - Reset, async: every output register and voice table entry = 0; state = IDLE; steal_ptr = 0.
//  - o_note_ready = (state==IDLE) && !i_all_off, combinational. It is 1 while in reset.
//  - FSM states: IDLE, SEARCH, SEL, WAV, FREQ, PANIC_SEL, PANIC_WR.
//  - IDLE:
//      i_all_off -> PANIC_SEL. Panic has priority over a simultaneous i_note_valid, which is not accepted.
//      Handshake at T0 -> latch event -> SEARCH.
//  - SEARCH: scans index 0..NUM_VOICES-1, one entry per cycle (T1..T64).
//      Records the lowest free index and the lowest active index whose note == latched note.
//  - SEARCH -> SEL at T65: target voice is selected and o_osc_sel is registered.
//      Note-on, match found: retrigger the matching voice.
//      Note-on, else free voice: use the lowest free voice.
//      Note-on, else: steal or drop (see CONFIGURATION).
//      Note-off, match found: target the matching voice.
//      Note-off, no match: no writes, return to IDLE at T65.
//  - WAV (note-on only, T66): o_wav_sel = latched wav; o_ws_valid = 1 for exactly 1 cycle.
//  - FREQ: o_t_freq = latched freq (note-on) or 0 (note-off); o_tf_valid = 1 for exactly 1 cycle.
//      Note-on reaches FREQ at T67; note-off skips WAV and reaches it at T66.
//  - Table update in the FREQ cycle: note-on sets active=1 and note; note-off clears active.
//  - Return to IDLE the cycle after FREQ (ready again at T68 for note-on).
//  - o_active_cnt updates in the same cycle as the table update. Range 0..NUM_VOICES.
//      Never increments on retrigger or steal.
//  - PANIC: for i = 0..NUM_VOICES-1, alternate PANIC_SEL (o_osc_sel = i) and PANIC_WR
//      (o_t_freq = 0, o_tf_valid = 1, clear entry i). Takes 2*NUM_VOICES cycles.
//      End state: o_active_cnt = 0, steal_ptr = 0. i_all_off during PANIC is ignored.
//  - o_osc_sel, o_t_freq and o_wav_sel hold their last values between writes.
//  - Reset mid-operation aborts immediately. No partial pulse may follow reset deassertion.
// CONFIGURATION
//  VOICE_STEAL_EN defined:
//      A note-on with no match and no free voice takes voice steal_ptr.
//      steal_ptr increments after each steal and wraps NUM_VOICES-1 -> 0.
//      The full WAV + FREQ write sequence follows; o_drop stays 0.
//  VOICE_STEAL_EN undefined:
//      The same case pulses o_drop in the SEL cycle (T65).
//      No write pulses, table unchanged, return to IDLE. steal_ptr logic is absent.
// TESTING
//  1. After reset, note-on note 69, freq 440, wav 3 -> T65 o_osc_sel=0; T66 ws_valid with wav 3;
//     T67 tf_valid with freq 440; T68 ready=1; active_cnt=1.
//  2. Note-on 60 then note-off 69 -> 60 goes to voice 1; off writes osc 0 with freq 0,
//     no ws_valid; active_cnt=1.
//  3. Note-off note 10 (never played) -> no pulses; ready=1 again at T66; active_cnt unchanged.
//  4. Fill 64 voices, then note-on 100 -> STEAL_EN: osc 0 rewritten, next steal uses osc 1;
//     else: o_drop pulse at T65, zero writes.
//  5. 3 voices active, i_all_off with note_valid held -> 64 tf_valid pulses, freq 0, osc 0..63 in order;
//     active_cnt=0; note accepted only after panic.
//  6. Assert reset at T30 of SEARCH -> all outputs 0 at once; after release, note-on lands on voice 0.

Source files
------------

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: table search then osc-select / wav / freq write sequence to the generator; VOICE_STEAL_EN enables round-robin stealing.
// Latency: event accepted at T0, osc_sel at T65, wav pulse T66, freq pulse T67 (note-off T66), ready again T68; panic takes 2*NUM_VOICES cycles.
// Backpressure: o_note_ready is high only in IDLE without a panic request; events are held off for the whole sequence.
module voice_alloc #(
    parameter int  NUM_VOICES = 64,
    parameter int  FREQ_W     = 24,
    localparam int OSC_W      = $clog2(NUM_VOICES)
) (
    input  logic              i_clk48,
    input  logic              i_rst48_n,
    input  logic              i_note_valid,
    output logic              o_note_ready,
    input  logic              i_note_on,
    input  logic [6:0]        i_note,
    input  logic [FREQ_W-1:0] i_freq,
    input  logic [7:0]        i_wav,
    input  logic              i_all_off,
    output logic [OSC_W-1:0]  o_osc_sel,
    output logic [FREQ_W-1:0] o_t_freq,
    output logic              o_tf_valid,
    output logic [7:0]        o_wav_sel,
    output logic              o_ws_valid,
    output logic              o_drop,
    output logic [OSC_W:0]    o_active_cnt
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEARCH    = 3'd1;
    localparam logic [2:0] SEL       = 3'd2;
    localparam logic [2:0] WAV       = 3'd3;
    localparam logic [2:0] FREQ      = 3'd4;
    localparam logic [2:0] PANIC_SEL = 3'd5;
    localparam logic [2:0] PANIC_WR  = 3'd6;

    localparam logic [OSC_W-1:0] LAST = OSC_W'(NUM_VOICES - 1);

    logic [2:0]                  state;
    logic [OSC_W-1:0]            idx;
    logic                        lat_on;
    logic [6:0]                  lat_note;
    logic [FREQ_W-1:0]           lat_freq;
    logic [7:0]                  lat_wav;
    logic                        free_found;
    logic [OSC_W-1:0]            free_idx;
    logic                        match_found;
    logic [OSC_W-1:0]            match_idx;
    logic                        sel_go;
    logic                        sel_inc;
    logic [NUM_VOICES-1:0]       active;
    logic [NUM_VOICES-1:0][6:0]  notes;
`ifdef VOICE_STEAL_EN
    logic [OSC_W-1:0]            steal_ptr;
`endif

    logic             cur_act;
    logic             cur_match;
    logic             fin_match;
    logic [OSC_W-1:0] fin_midx;
    logic             fin_free;
    logic [OSC_W-1:0] fin_fidx;
    logic             enter_freq;

    assign o_note_ready = (state == IDLE) && !i_all_off;

    // Final search result folds in the entry being scanned this cycle.
    assign cur_act    = active[idx];
    assign cur_match  = cur_act && (notes[idx] == lat_note);
    assign fin_match  = match_found || cur_match;
    assign fin_midx   = match_found ? match_idx : idx;
    assign fin_free   = free_found || !cur_act;
    assign fin_fidx   = free_found ? free_idx : idx;
    assign enter_freq = (state == WAV) || ((state == SEL) && sel_go && !lat_on);

    always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
        if (!i_rst48_n) begin
            state        <= IDLE;
            idx          <= '0;
            lat_on       <= 1'b0;
            lat_note     <= '0;
            lat_freq     <= '0;
            lat_wav      <= '0;
            free_found   <= 1'b0;
            free_idx     <= '0;
            match_found  <= 1'b0;
            match_idx    <= '0;
            sel_go       <= 1'b0;
            sel_inc      <= 1'b0;
            active       <= '0;
            notes        <= '0;
            o_osc_sel    <= '0;
            o_t_freq     <= '0;
            o_tf_valid   <= 1'b0;
            o_wav_sel    <= '0;
            o_ws_valid   <= 1'b0;
            o_drop       <= 1'b0;
            o_active_cnt <= '0;
`ifdef VOICE_STEAL_EN
            steal_ptr    <= '0;
`endif
        end else begin
            o_tf_valid <= 1'b0;
            o_ws_valid <= 1'b0;
            o_drop     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_all_off) begin
                        state     <= PANIC_SEL;
                        idx       <= '0;
                        o_osc_sel <= '0;
                    end else if (i_note_valid) begin
                        state       <= SEARCH;
                        idx         <= '0;
                        lat_on      <= i_note_on;
                        lat_note    <= i_note;
                        lat_freq    <= i_freq;
                        lat_wav     <= i_wav;
                        free_found  <= 1'b0;
                        match_found <= 1'b0;
                    end
                end
                SEARCH: begin
                    idx <= idx + 1'b1;
                    if (!free_found && !cur_act) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (!match_found && cur_match) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (idx == LAST) begin
                        state   <= SEL;
                        sel_go  <= 1'b0;
                        sel_inc <= 1'b0;
                        if (fin_match) begin
                            o_osc_sel <= fin_midx;
                            sel_go    <= 1'b1;
                        end else if (lat_on && fin_free) begin
                            o_osc_sel <= fin_fidx;
                            sel_go    <= 1'b1;
                            sel_inc   <= 1'b1;
                        end else if (lat_on) begin
`ifdef VOICE_STEAL_EN
                            o_osc_sel <= steal_ptr;
                            steal_ptr <= steal_ptr + 1'b1;
                            sel_go    <= 1'b1;
`else
                            o_drop    <= 1'b1;
`endif
                        end
                    end
                end
                SEL: begin
                    if (!sel_go) begin
                        state <= IDLE;
                    end else if (lat_on) begin
                        state      <= WAV;
                        o_wav_sel  <= lat_wav;
                        o_ws_valid <= 1'b1;
                    end else begin
                        state <= FREQ;
                    end
                end
                WAV:  state <= FREQ;
                FREQ: state <= IDLE;
                PANIC_SEL: begin
                    state      <= PANIC_WR;
                    o_t_freq   <= '0;
                    o_tf_valid <= 1'b1;
                    active[idx] <= 1'b0;
                    notes[idx]  <= '0;
                    if (active[idx])
                        o_active_cnt <= o_active_cnt - 1'b1;
                end
                PANIC_WR: begin
                    if (idx == LAST) begin
                        state <= IDLE;
                        idx   <= '0;
`ifdef VOICE_STEAL_EN
                        steal_ptr <= '0;
`endif
                    end else begin
                        state     <= PANIC_SEL;
                        idx       <= idx + 1'b1;
                        o_osc_sel <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Shared by note-on (from WAV) and note-off (straight from SEL).
            if (enter_freq) begin
                o_t_freq          <= lat_on ? lat_freq : '0;
                o_tf_valid        <= 1'b1;
                active[o_osc_sel] <= lat_on;
                if (lat_on)
                    notes[o_osc_sel] <= lat_note;
                if (lat_on && sel_inc)
                    o_active_cnt <= o_active_cnt + 1'b1;
                else if (!lat_on)
                    o_active_cnt <= o_active_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_voice_alloc.sv
// Scoreboard bench for voice_alloc: array-based allocation model feeds expected generator writes to a queue, a monitor pops them.
`timescale 1ns/1ps
module tb_voice_alloc;

    logic        i_clk48 = 1'b0;
    logic        i_rst48_n = 1'b1;
    logic        i_note_valid = 1'b0;
    logic        o_note_ready;
    logic        i_note_on = 1'b0;
    logic [6:0]  i_note = '0;
    logic [23:0] i_freq = '0;
    logic [7:0]  i_wav = '0;
    logic        i_all_off = 1'b0;
    logic [5:0]  o_osc_sel;
    logic [23:0] o_t_freq;
    logic        o_tf_valid;
    logic [7:0]  o_wav_sel;
    logic        o_ws_valid;
    logic        o_drop;
    logic [6:0]  o_active_cnt;

    voice_alloc dut (
        .i_clk48      (i_clk48),
        .i_rst48_n    (i_rst48_n),
        .i_note_valid (i_note_valid),
        .o_note_ready (o_note_ready),
        .i_note_on    (i_note_on),
        .i_note       (i_note),
        .i_freq       (i_freq),
        .i_wav        (i_wav),
        .i_all_off    (i_all_off),
        .o_osc_sel    (o_osc_sel),
        .o_t_freq     (o_t_freq),
        .o_tf_valid   (o_tf_valid),
        .o_wav_sel    (o_wav_sel),
        .o_ws_valid   (o_ws_valid),
        .o_drop       (o_drop),
        .o_active_cnt (o_active_cnt)
    );

    always #10 i_clk48 = ~i_clk48;

    int cyc = 0;
    always @(posedge i_clk48) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind: 0 = waveform write, 1 = frequency write, 2 = drop pulse
    typedef struct {
        int     kind;
        int     osc;
        longint val;
        int     cyc;
    } exp_t;
    exp_t sb[$];

    bit m_act[64];
    int m_note[64];
    int m_steal = 0;

    function automatic int m_cnt();
        int c = 0;
        foreach (m_act[i]) c += m_act[i];
        return c;
    endfunction

    task automatic push(input int kind, input int osc, input longint val, input int c);
        exp_t e;
        e.kind = kind; e.osc = osc; e.val = val; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic model_clear();
        foreach (m_act[i]) begin
            m_act[i] = 1'b0;
            m_note[i] = 0;
        end
        m_steal = 0;
    endtask

    // Expected writes and ready latency (cycles after T0) of one event.
    task automatic model_note(input bit on, input int n, input longint f, input int w,
                              input int c0, output int lat);
        int mi = -1;
        int fi = -1;
        int tgt = 0;
        for (int i = 0; i < 64; i++) begin
            if (mi < 0 && m_act[i] && m_note[i] == n) mi = i;
            if (fi < 0 && !m_act[i]) fi = i;
        end
        if (on) begin
            if (mi >= 0) tgt = mi;
            else if (fi >= 0) tgt = fi;
            else begin
`ifdef VOICE_STEAL_EN
                tgt = m_steal;
                m_steal = (m_steal + 1) % 64;
`else
                push(2, 0, 0, c0 + 65);
                lat = 66;
                return;
`endif
            end
            push(0, tgt, w, c0 + 66);
            push(1, tgt, f, c0 + 67);
            m_act[tgt] = 1'b1;
            m_note[tgt] = n;
            lat = 68;
        end else if (mi >= 0) begin
            push(1, mi, 0, c0 + 66);
            m_act[mi] = 1'b0;
            lat = 67;
        end else begin
            lat = 66;
        end
    endtask

    int prev_osc = 0;

    task automatic mon(input int kind, input int osc, input longint val);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_pulse_kind", kind, -1);
            return;
        end
        e = sb.pop_front();
        chk("pulse_kind", kind, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        if (kind != 2) begin
            chk("pulse_osc", osc, e.osc);
            chk("pulse_data", val, e.val);
            chk("osc_stable", prev_osc, osc);
        end
    endtask

    always @(negedge i_clk48) begin
        if (i_rst48_n) begin
            if (o_ws_valid) mon(0, o_osc_sel, o_wav_sel);
            if (o_tf_valid) mon(1, o_osc_sel, o_t_freq);
            if (o_drop)     mon(2, 0, 0);
        end
        prev_osc = o_osc_sel;
    end

    task automatic do_note(input bit on, input int n, input longint f, input int w,
                           input bit wait_done, output int c0);
        int lat;
        int b;
        @(negedge i_clk48);
        b = 0;
        while (!o_note_ready && b < 400) begin
            @(negedge i_clk48);
            b++;
        end
        chk("ready_wait", o_note_ready, 1);
        c0 = cyc;
        model_note(on, n, f, w, c0, lat);
        i_note_valid = 1'b1;
        i_note_on = on;
        i_note = 7'(n);
        i_freq = 24'(f);
        i_wav = 8'(w);
        @(negedge i_clk48);
        i_note_valid = 1'b0;
        if (wait_done) begin
            b = 0;
            while (!o_note_ready && b < 200) begin
                @(negedge i_clk48);
                b++;
            end
            chk("ready_latency", cyc - c0, lat);
            chk("active_cnt", o_active_cnt, m_cnt());
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ready"}, o_note_ready, 1);
        chk({tag, "_osc_sel"}, o_osc_sel, 0);
        chk({tag, "_t_freq"}, o_t_freq, 0);
        chk({tag, "_wav_sel"}, o_wav_sel, 0);
        chk({tag, "_pulses"}, {o_tf_valid, o_ws_valid, o_drop}, 0);
        chk({tag, "_active_cnt"}, o_active_cnt, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int cn;
        int lat;
        int b;
        bit r_on;

        model_clear();
        #5 i_rst48_n = 1'b0;
        #30;
        chk_outs_zero("reset");
        @(negedge i_clk48);
        i_rst48_n = 1'b1;

        // First note lands on voice 0 with the exact write timing.
        do_note(1, 69, 440, 3, 1, c0);
        do_note(1, 60, 1000, 0, 1, c0);
        do_note(0, 69, 0, 0, 1, c0);
        // Note-off for a note never played: no writes.
        do_note(0, 10, 0, 0, 1, c0);
        // Retrigger of an active note keeps the count.
        do_note(1, 60, 2000, 1, 1, c0);
        do_note(1, 70, 700, 2, 1, c0);
        do_note(1, 71, 710, 3, 1, c0);

        // Panic with a note-on held valid alongside it.
        @(negedge i_clk48);
        c0 = cyc;
        for (int i = 0; i < 64; i++) push(1, i, 0, c0 + 2 + 2 * i);
        model_clear();
        i_all_off = 1'b1;
        i_note_valid = 1'b1;
        i_note_on = 1'b1;
        i_note = 7'd33;
        i_freq = 24'd3300;
        i_wav = 8'd2;
        @(negedge i_clk48);
        i_all_off = 1'b0;
        chk("panic_ready_low", o_note_ready, 0);
        b = 0;
        while (!o_note_ready && b < 300) begin
            @(negedge i_clk48);
            b++;
        end
        chk("panic_length", cyc - c0, 129);
        chk("panic_cnt", o_active_cnt, 0);
        cn = cyc;
        model_note(1, 33, 3300, 2, cn, lat);
        @(negedge i_clk48);
        i_note_valid = 1'b0;
        b = 0;
        while (!o_note_ready && b < 200) begin
            @(negedge i_clk48);
            b++;
        end
        chk("post_panic_latency", cyc - cn, lat);
        chk("post_panic_cnt", o_active_cnt, m_cnt());

        // Random traffic over a small note range to exercise match/free paths.
        for (int k = 0; k < 40; k++) begin
            r_on = ($urandom_range(0, 9) < 6);
            do_note(r_on, $urandom_range(0, 15), $urandom_range(1, 24'hFFFFFF),
                    $urandom_range(0, 3), 1, c0);
        end

        // Fill every voice, then overflow twice (steal or drop).
        for (int i = 0; i < 63 && m_cnt() < 64; i++)
            do_note(1, 64 + i, $urandom_range(1, 20000), $urandom_range(0, 3), 1, c0);
        chk("full_cnt", o_active_cnt, 64);
        do_note(1, 127, 5555, 1, 1, c0);
        do_note(1, 20, 6666, 2, 1, c0);
        chk("overflow_cnt", o_active_cnt, 64);

        // Reset in the middle of a search aborts everything.
        do_note(1, 5, 1234, 2, 0, c0);
        while (cyc < c0 + 30) @(negedge i_clk48);
        i_rst48_n = 1'b0;
        sb.delete();
        model_clear();
        #1;
        chk_outs_zero("midreset");
        repeat (3) @(negedge i_clk48);
        i_rst48_n = 1'b1;
        do_note(1, 77, 4321, 1, 1, c0);
        chk("post_reset_osc", o_osc_sel, 0);

        repeat (4) @(negedge i_clk48);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
